// File: rtl/gps_navi_pkg.sv
// Shared widths, state encoding and message packing for the GPS subframe encoder.
// Contents: WORDS_PER_SF, DATA_BITS, WORD_BITS, derived widths, state_t, pack_msg().
package gps_navi_pkg;

    localparam int unsigned WORDS_PER_SF = 10;
    localparam int unsigned DATA_BITS    = 24;
    localparam int unsigned WORD_BITS    = 30;
    localparam int unsigned PARITY_BITS  = WORD_BITS - DATA_BITS;
    localparam int unsigned CNT_BITS     = $clog2(WORDS_PER_SF);
    localparam int unsigned MSG_BITS     = 64;
    localparam int unsigned MSG_COUNT    = WORDS_PER_SF / 2;

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_PEND    = 1'b1
    } state_t;

    // Two encoded words per message: the even-numbered word sits in the upper field.
    function automatic logic [MSG_BITS-1:0] pack_msg(
        input logic [WORD_BITS-1:0] even_word,
        input logic [WORD_BITS-1:0] odd_word
    );
        return {2'b00, even_word, 2'b00, odd_word};
    endfunction

endpackage : gps_navi_pkg

// File: rtl/gps_parity_word.sv
// Combinational IS-GPS-200 word encoder (Table 20-XIV).
// Ports:
//   data     [23:0] source bits d1..d24, d1 at bit 23
//   d29_star        D29 of the previously transmitted word
//   d30_star        D30 of the previously transmitted word
//   word_c   [29:0] transmitted word D1..D30, D1 at bit 29
module gps_parity_word
    import gps_navi_pkg::*;
(
    input  logic [DATA_BITS-1:0] data,
    input  logic                 d29_star,
    input  logic                 d30_star,
    output logic [WORD_BITS-1:0] word_c
);

    // dd[k] is source bit dk, so the equations read like the ICD table.
    logic [DATA_BITS:1]     dd;
    logic [PARITY_BITS-1:0] par;

    assign dd = {<<{data}};

    // par[5] is D25 ... par[0] is D30; parity is formed from the uncomplemented dk.
    always_comb begin
        par    = '0;
        par[5] = d29_star ^ dd[1] ^ dd[2] ^ dd[3] ^ dd[5] ^ dd[6] ^ dd[10] ^ dd[11]
               ^ dd[12] ^ dd[13] ^ dd[14] ^ dd[17] ^ dd[18] ^ dd[20] ^ dd[23];
        par[4] = d30_star ^ dd[2] ^ dd[3] ^ dd[4] ^ dd[6] ^ dd[7] ^ dd[11] ^ dd[12]
               ^ dd[13] ^ dd[14] ^ dd[15] ^ dd[18] ^ dd[19] ^ dd[21] ^ dd[24];
        par[3] = d29_star ^ dd[1] ^ dd[3] ^ dd[4] ^ dd[5] ^ dd[7] ^ dd[8] ^ dd[12]
               ^ dd[13] ^ dd[14] ^ dd[15] ^ dd[16] ^ dd[19] ^ dd[20] ^ dd[22];
        par[2] = d30_star ^ dd[2] ^ dd[4] ^ dd[5] ^ dd[6] ^ dd[8] ^ dd[9] ^ dd[13]
               ^ dd[14] ^ dd[15] ^ dd[16] ^ dd[17] ^ dd[20] ^ dd[21] ^ dd[23];
        par[1] = d30_star ^ dd[1] ^ dd[3] ^ dd[5] ^ dd[6] ^ dd[7] ^ dd[9] ^ dd[10]
               ^ dd[14] ^ dd[15] ^ dd[16] ^ dd[17] ^ dd[18] ^ dd[21] ^ dd[22] ^ dd[24];
        par[0] = d29_star ^ dd[3] ^ dd[5] ^ dd[6] ^ dd[8] ^ dd[9] ^ dd[10] ^ dd[11]
               ^ dd[13] ^ dd[15] ^ dd[19] ^ dd[22] ^ dd[23] ^ dd[24];
    end

    // Data bits go out complemented when the previous word ended in D30=1.
    assign word_c = {data ^ {DATA_BITS{d30_star}}, par};

endmodule : gps_parity_word

// File: rtl/gps_subframe_encoder.sv
// Collects ten 24-bit source words, parity-encodes them into a working buffer and
// publishes the subframe on message1..5 when the downstream 6 s tick asks for it
// (the very first subframe after reset publishes immediately).
// Optional build macro: GPS_NAVI_TBIT_SOLVE_EN -- words 2 and 10 get d23,d24
// recomputed so that their D29=D30=0.
// Ports:
//   clk, rst (async, active low)
//   in_valid, in_data[23:0], in_ready   source handshake
//   time6s_sign, shut_time6s_sign        serializer request / one-cycle acknowledge
//   message1..message5[63:0]             published subframe
//   frame_pending                        a finished subframe awaits publication
module gps_subframe_encoder
    import gps_navi_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 in_ready,
    input  logic                 time6s_sign,
    output logic                 shut_time6s_sign,
    output logic [MSG_BITS-1:0]  message1,
    output logic [MSG_BITS-1:0]  message2,
    output logic [MSG_BITS-1:0]  message3,
    output logic [MSG_BITS-1:0]  message4,
    output logic [MSG_BITS-1:0]  message5,
    output logic                 frame_pending
);

    state_t               state;
    state_t               state_next;
    logic                 first_frame;
    logic                 first_frame_next;
    logic                 in_ready_next;
    logic                 pending_next;
    logic                 shut_next;
    logic                 accept_c;
    logic                 publish_c;
    logic                 last_word_c;
    logic [CNT_BITS-1:0]  word_cnt;
    logic                 d29_star;
    logic                 d30_star;
    logic [WORD_BITS-1:0] work [WORDS_PER_SF];
    logic [DATA_BITS-1:0] data_c;
    logic [WORD_BITS-1:0] word_c;

    assign accept_c    = in_valid && in_ready;
    assign last_word_c = (word_cnt == CNT_BITS'(WORDS_PER_SF - 1));

`ifdef GPS_NAVI_TBIT_SOLVE_EN
    // Encode once with d23=d24=0; parity is linear, so the probe's D29/D30
    // give the d23/d24 that cancel them (D29 uses d24, D30 uses d23 and d24).
    logic [WORD_BITS-1:0] probe_c;
    logic                 fix_slot_c;

    gps_parity_word u_probe (
        .data     ({in_data[DATA_BITS-1:2], 2'b00}),
        .d29_star (d29_star),
        .d30_star (d30_star),
        .word_c   (probe_c)
    );

    assign fix_slot_c = (word_cnt == CNT_BITS'(1)) || (word_cnt == CNT_BITS'(WORDS_PER_SF - 1));
    assign data_c     = fix_slot_c ? {in_data[DATA_BITS-1:2], probe_c[1] ^ probe_c[0], probe_c[1]}
                                   : in_data;
`else
    assign data_c = in_data;
`endif

    gps_parity_word u_parity (
        .data     (data_c),
        .d29_star (d29_star),
        .d30_star (d30_star),
        .word_c   (word_c)
    );

    // Next-state and registered-output decode.
    always_comb begin
        state_next       = state;
        first_frame_next = first_frame;
        shut_next        = 1'b0;
        publish_c        = 1'b0;
        case (state)
            ST_COLLECT: begin
                if (accept_c && last_word_c) begin
                    state_next = ST_PEND;
                end
            end
            ST_PEND: begin
                if (first_frame || time6s_sign) begin
                    state_next       = ST_COLLECT;
                    first_frame_next = 1'b0;
                    shut_next        = 1'b1;
                    publish_c        = 1'b1;
                end
            end
            default: state_next = ST_COLLECT;
        endcase
        in_ready_next = (state_next == ST_COLLECT);
        pending_next  = (state_next == ST_PEND);
    end

    // State and control-output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= ST_COLLECT;
            first_frame      <= 1'b1;
            in_ready         <= 1'b1;
            frame_pending    <= 1'b0;
            shut_time6s_sign <= 1'b0;
        end else begin
            state            <= state_next;
            first_frame      <= first_frame_next;
            in_ready         <= in_ready_next;
            frame_pending    <= pending_next;
            shut_time6s_sign <= shut_next;
        end
    end

    // Working buffer, parity history and word slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_cnt <= '0;
            d29_star <= 1'b0;
            d30_star <= 1'b0;
            for (int i = 0; i < WORDS_PER_SF; i++) begin
                work[i] <= '0;
            end
        end else if (accept_c) begin
            work[word_cnt] <= word_c;
            d29_star       <= word_c[1];
            d30_star       <= word_c[0];
            word_cnt       <= last_word_c ? '0 : word_cnt + CNT_BITS'(1);
        end
    end

    // Published messages change only on the publication edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            message1 <= '0;
            message2 <= '0;
            message3 <= '0;
            message4 <= '0;
            message5 <= '0;
        end else if (publish_c) begin
            message1 <= pack_msg(work[1], work[0]);
            message2 <= pack_msg(work[3], work[2]);
            message3 <= pack_msg(work[5], work[4]);
            message4 <= pack_msg(work[7], work[6]);
            message5 <= pack_msg(work[9], work[8]);
        end
    end

endmodule : gps_subframe_encoder

// File: tb/tb_gps_subframe_encoder.sv
// Randomized self-checking bench for gps_subframe_encoder against a table-driven
// IS-GPS-200 reference model; honours GPS_NAVI_TBIT_SOLVE_EN when defined.
module tb_gps_subframe_encoder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [23:0] in_data;
    logic        in_ready;
    logic        time6s_sign;
    logic        shut_time6s_sign;
    logic [63:0] message1, message2, message3, message4, message5;
    logic        frame_pending;
    logic [63:0] msg_obs [5];

    gps_subframe_encoder dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_ready         (in_ready),
        .time6s_sign      (time6s_sign),
        .shut_time6s_sign (shut_time6s_sign),
        .message1         (message1),
        .message2         (message2),
        .message3         (message3),
        .message4         (message4),
        .message5         (message5),
        .frame_pending    (frame_pending)
    );

    assign msg_obs[0] = message1;
    assign msg_obs[1] = message2;
    assign msg_obs[2] = message3;
    assign msg_obs[3] = message4;
    assign msg_obs[4] = message5;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ICD parity table: source-bit lists for D25..D30 (0 = unused slot) and
    // which previous-word bit seeds each (0: D29*, 1: D30*).
    localparam int PT [6][16] = '{
        '{1,2,3,5,6,10,11,12,13,14,17,18,20,23,0,0},
        '{2,3,4,6,7,11,12,13,14,15,18,19,21,24,0,0},
        '{1,3,4,5,7,8,12,13,14,15,16,19,20,22,0,0},
        '{2,4,5,6,8,9,13,14,15,16,17,20,21,23,0,0},
        '{1,3,5,6,7,9,10,14,15,16,17,18,21,22,24,0},
        '{3,5,6,8,9,10,11,13,15,19,22,23,24,0,0,0}
    };
    localparam int PSTAR [6] = '{0,1,0,1,1,0};

    int n_cmp;
    int n_bad;
    int shut_cnt;

    // Reference model state.
    logic [29:0] exp_work [10];
    logic [63:0] pub_msg  [5];
    int          m_cnt;
    logic        m_p29;
    logic        m_p30;
    bit          m_first;
    logic [23:0] last_d2;

    // Downstream serializer: the acknowledge clears its request flag.
    always @(negedge clk) begin
        if (shut_time6s_sign) begin
            shut_cnt++;
            time6s_sign = 1'b0;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [29:0] ref_encode(input logic [23:0] d, input logic p29, input logic p30);
        logic [29:0] w;
        logic        par;
        for (int k = 1; k <= 24; k++) w[30-k] = d[24-k] ^ p30;
        for (int j = 0; j < 6; j++) begin
            par = (PSTAR[j] == 1) ? p30 : p29;
            for (int t = 0; t < 16; t++) begin
                if (PT[j][t] != 0) par = par ^ d[24-PT[j][t]];
            end
            w[5-j] = par;
        end
        return w;
    endfunction

    // With the t-bit option, search the four d23/d24 choices for D29=D30=0.
    function automatic logic [23:0] ref_fix(input logic [23:0] d, input int idx,
                                            input logic p29, input logic p30);
        logic [23:0] out;
        out = d;
`ifdef GPS_NAVI_TBIT_SOLVE_EN
        if (idx == 1 || idx == 9) begin
            for (int c = 0; c < 4; c++) begin
                logic [23:0] cand;
                logic [29:0] w;
                cand = {d[23:2], 2'(c)};
                w    = ref_encode(cand, p29, p30);
                if (w[1:0] == 2'b00) out = cand;
            end
        end
`endif
        return out;
    endfunction

    function automatic logic [63:0] ref_msg(input int m);
        return {2'b00, exp_work[2*m+1], 2'b00, exp_work[2*m]};
    endfunction

    task automatic model_reset();
        m_cnt   = 0;
        m_p29   = 1'b0;
        m_p30   = 1'b0;
        m_first = 1'b1;
        for (int i = 0; i < 10; i++) exp_work[i] = '0;
        for (int m = 0; m < 5; m++) pub_msg[m] = '0;
    endtask

    task automatic model_accept(input logic [23:0] d);
        logic [29:0] w;
        if (m_cnt == 1) last_d2 = d;
        w              = ref_encode(ref_fix(d, m_cnt, m_p29, m_p30), m_p29, m_p30);
        exp_work[m_cnt] = w;
        m_p29          = w[1];
        m_p30          = w[0];
        m_cnt          = (m_cnt == 9) ? 0 : m_cnt + 1;
    endtask

    // Offer one word after up to stall_max idle cycles of noise on in_data.
    task automatic push(input logic [23:0] d, input int stall_max);
        int st;
        int n;
        st = (stall_max > 0) ? int'($urandom_range(stall_max, 0)) : 0;
        @(negedge clk);
        for (int s = 0; s < st; s++) begin
            in_valid = 1'b0;
            in_data  = 24'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("accept_wait", 64'(n >= 50), 64'(0));
        @(posedge clk);
        model_accept(d);
        #1;
        in_valid = 1'b0;
    endtask

    // Called right after the 10th word's accepting edge.
    task automatic frame_done();
        int base;
        bit immediate;
        base = shut_cnt;
        check_eq("pending_set", 64'(frame_pending), 64'(1));
        check_eq("ready_low", 64'(in_ready), 64'(0));
        immediate = m_first || (time6s_sign == 1'b1);
        if (!immediate) begin
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                in_valid = 1'b1;
                in_data  = 24'($urandom);
                @(posedge clk);
                #1;
                check_eq("hold_pending", 64'(frame_pending), 64'(1));
                check_eq("hold_ready", 64'(in_ready), 64'(0));
                check_eq("hold_shut", 64'(shut_time6s_sign), 64'(0));
                for (int m = 0; m < 5; m++) check_eq("hold_msg", msg_obs[m], pub_msg[m]);
            end
            @(negedge clk);
            time6s_sign = 1'b1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_eq("pub_shut", 64'(shut_time6s_sign), 64'(1));
        check_eq("pub_pending", 64'(frame_pending), 64'(0));
        check_eq("pub_ready", 64'(in_ready), 64'(1));
        for (int m = 0; m < 5; m++) begin
            pub_msg[m] = ref_msg(m);
            check_eq("pub_msg", msg_obs[m], pub_msg[m]);
        end
`ifdef GPS_NAVI_TBIT_SOLVE_EN
        check_eq("tbit_w2", 64'(msg_obs[0][33:32]), 64'(0));
        check_eq("tbit_w10", 64'(msg_obs[4][33:32]), 64'(0));
`else
        check_eq("w2_d23_d24", 64'(msg_obs[0][39:38] ^ {2{msg_obs[0][0]}}), 64'(last_d2[1:0]));
`endif
        m_first = 1'b0;
        @(posedge clk);
        #1;
        check_eq("shut_drop", 64'(shut_time6s_sign), 64'(0));
        check_eq("shut_count", 64'(shut_cnt - base), 64'(1));
    endtask

    // mode 0: random, 1: all zero, 2: random with word3 ending D30=1 and word4 zero.
    task automatic run_frame(input int mode, input int stall_max, input int t6_after);
        logic [23:0] d;
        for (int i = 0; i < 10; i++) begin
            d = (mode == 1) ? 24'h0 : 24'($urandom);
            if (mode == 2 && i == 2) begin
                while (ref_encode(d, m_p29, m_p30) % 2 == 0) d = 24'($urandom);
            end
            if (mode == 2 && i == 3) d = 24'h0;
            push(d, stall_max);
            if (i == t6_after) begin
                @(negedge clk);
                time6s_sign = 1'b1;
            end
        end
        frame_done();
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        shut_cnt    = 0;
        last_d2     = '0;
        rst         = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        time6s_sign = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        for (int m = 0; m < 5; m++) check_eq("rst_msg", msg_obs[m], 64'(0));
        check_eq("rst_shut", 64'(shut_time6s_sign), 64'(0));
        check_eq("rst_pending", 64'(frame_pending), 64'(0));
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_ready", 64'(in_ready), 64'(1));

        // First subframe of zeros publishes without a 6 s request.
        run_frame(1, 0, -1);
        for (int m = 0; m < 5; m++) check_eq("zero_msg", msg_obs[m], 64'(0));

        // Complemented data after D30=1; publication waits for the request.
        run_frame(2, 0, -1);
        check_eq("d30_invert", 64'(msg_obs[1][61:38]), 64'(24'hFFFFFF));

        // Request raised mid-collection stays latched and is serviced in PEND.
        run_frame(0, 3, 4);

        // Stalled random bursts.
        run_frame(0, 4, -1);
        run_frame(0, 2, -1);

        // Reset mid-subframe: messages clear at once, partial words are dropped.
        for (int i = 0; i < 5; i++) push(24'($urandom), 2);
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int m = 0; m < 5; m++) check_eq("midrst_msg", msg_obs[m], 64'(0));
        check_eq("midrst_pending", 64'(frame_pending), 64'(0));
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_ready", 64'(in_ready), 64'(1));
        run_frame(0, 2, -1);
        run_frame(0, 1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

endmodule : tb_gps_subframe_encoder

// File: doc/gps_subframe_encoder.md
GPS_SUBFRAME_ENCODER -- requirements
Module: gps_subframe_encoder

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-002 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port in_valid, input, 1 bit: in_data holds one word's source bits.
REQ-004 The block SHALL have port in_data, input, 24 bits: data bits d1..d24, with d1 at bit 23.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts a word this cycle.
REQ-006 The block SHALL have port time6s_sign, input, 1 bit: the downstream serializer has loaded its buffer.
REQ-007 The block SHALL have port shut_time6s_sign, output, 1 bit: one-cycle acknowledge that clears time6s_sign downstream.
REQ-008 The block SHALL have ports message1..message5, output, 64 bits each: the published subframe.
REQ-009 The block SHALL have port frame_pending, output, 1 bit: an encoded subframe awaits publication.

Function
REQ-010 The block SHALL implement the states COLLECT and PEND.
REQ-011 in_ready SHALL equal 1 only in COLLECT; a word SHALL be accepted on any edge where in_valid=1 and in_ready=1.
REQ-012 Each accepted word SHALL be encoded per IS-GPS-200 (Table 20-XIV): transmitted bits D1..D24 = dk XOR D30*; parity D25..D30 computed from dk, D29* and D30*.
REQ-013 D29* and D30* SHALL be the D29/D30 of the previously encoded word, carried across subframe boundaries, and SHALL reset to 0.
REQ-014 word_cnt (0..9) SHALL select the slot and increment per accepted word; on the 10th accepted word it SHALL wrap to 0 and the state SHALL become PEND.
REQ-015 Word n SHALL be packed into message((n+1)/2); odd n uses bits [29:0], even n uses bits [61:32]; D1 (first transmitted) SHALL be at the highest bit of each field.
REQ-016 Bits [63:62] and [31:30] of every message SHALL always be 0.
REQ-017 Encoded words SHALL be written to an internal working buffer; message1..5 SHALL change only at publication.
REQ-018 Publication: in PEND with (first_frame=1 or time6s_sign=1), the next edge SHALL copy the working buffer to message1..5, drive shut_time6s_sign=1 for exactly that one cycle, clear first_frame and return to COLLECT.
REQ-019 first_frame SHALL be 1 after reset, so the first subframe publishes without waiting for time6s_sign.
REQ-020 frame_pending SHALL be 1 exactly while in PEND.
REQ-021 A time6s_sign seen in COLLECT SHALL be ignored; it SHALL stay latched downstream until it is serviced in PEND.
REQ-022 in_data and in_valid SHALL be ignored while in_ready=0; the source stalls.

Reset
REQ-023 On rst=0 the block SHALL asynchronously clear message1..5, the working buffer, D29*/D30* and word_cnt.
REQ-024 On rst=0 the block SHALL set shut_time6s_sign=0, set first_frame=1 and enter COLLECT; in_ready SHALL be 1 once rst=1.
REQ-025 A reset mid-subframe SHALL discard any partial words.

Configuration
REQ-026 Macro GPS_NAVI_TBIT_SOLVE_EN: when defined, for words 2 and 10 the block SHALL replace d23,d24 with the values that force D29=D30=0, before parity is computed.
REQ-027 Without GPS_NAVI_TBIT_SOLVE_EN, d23,d24 SHALL pass through unchanged.

Structure
REQ-028 Package gps_navi_pkg SHALL hold WORDS_PER_SF=10, DATA_BITS=24, WORD_BITS=30 and the state encoding.
REQ-029 The parity equations SHALL reside in a combinational sub-module, gps_parity_word (inputs: 24-bit data, D29*, D30*; output: 30-bit word).

Verification
REQ-030 Reset, then 10 words of 0x000000 -> shut_time6s_sign pulses once, message1..5 = 0, frame_pending returns to 0.
REQ-031 Word with D30=1, then next data 0x000000 -> that word's D1..D24 = 0xFFFFFF; parity matches the golden model.
REQ-032 Second subframe completes with time6s_sign=0 -> frame_pending=1, in_ready=0 and messages unchanged; raise time6s_sign -> publish next edge, with one-cycle shut_time6s_sign.
REQ-033 Stall in_valid randomly during a 10-word burst -> only handshaken words are stored; packing is per REQ-015.
REQ-034 GPS_NAVI_TBIT_SOLVE_EN defined, random data -> bits D29,D30 of words 2 and 10 = 0; undefined -> d23,d24 are unchanged.
REQ-035 Assert rst=0 after 5 words -> messages are 0 immediately, and the next 10 words publish without time6s_sign.
